// File: rtl/mm_port_arbiter.sv
// mm_port_arbiter: shares the single matrix-memory port between the host loader (requester 0)
// and the MM engine (requester 1). Grants are registered and held while the owner keeps req
// high. Release hands over round-robin without an idle bubble.
// Optional burst cap: define MM_ARB_BURST_CAP_EN to force a handover after MAX_BURST granted
// cycles whenever the other requester is waiting.
module mm_port_arbiter #(
    parameter int unsigned N         = 20,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             rd0,
    input  logic             rd1,
    input  logic             wr0,
    input  logic             wr1,
    input  logic             idx0,
    input  logic             idx1,
    input  logic [N-1:0]     i0,
    input  logic [N-1:0]     i1,
    input  logic [N-1:0]     j0,
    input  logic [N-1:0]     j1,
    input  logic [2*N-1:0]   wdata0,
    input  logic [2*N-1:0]   wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_index,
    output logic [N-1:0]     mem_i,
    output logic [N-1:0]     mem_j,
    output logic [2*N-1:0]   mem_wdata,
    input  logic [N-1:0]     mem_rdata,
    output logic [N-1:0]     rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;

    // A burst cap below 2 would hand over before the owner ever gets a full access in.
    if (MAX_BURST < 2) begin : g_bad_max_burst
        $error("MAX_BURST must be at least 2");
    end

`ifdef MM_ARB_BURST_CAP_EN
    localparam int unsigned CntW = $clog2(MAX_BURST);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cap0, cap1;

    // Burst exhausted and the other side is waiting: preempt the current owner.
    assign cap0 = (cnt_q == CntMax) && req1;
    assign cap1 = (cnt_q == CntMax) && req0;
`else
    logic cap0, cap1;

    assign cap0 = 1'b0;
    assign cap1 = 1'b0;
`endif

    // Next-state and last-served pointer: tie goes to the requester not served last.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    state_d = last_q ? StOwn0 : StOwn1;
                end else if (req0) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!req0 || cap0) begin
                    last_d  = 1'b0;
                    state_d = req1 ? StOwn1 : StIdle;
                end
            end
            StOwn1: begin
                if (!req1 || cap1) begin
                    last_d  = 1'b1;
                    state_d = req0 ? StOwn0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef MM_ARB_BURST_CAP_EN
    // Burst counter: restarts on every ownership change, saturates at MAX_BURST-1.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != StIdle && cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Burst counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // Arbiter state; last=1 after reset so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign gnt0  = (state_q == StOwn0);
    assign gnt1  = (state_q == StOwn1);
    assign rdata = mem_rdata;

    // Forward the owner's command; strobes are qualified by its req so a released
    // requester cannot slip an access through in its last granted cycle.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_index = 1'b0;
        mem_i     = '0;
        mem_j     = '0;
        mem_wdata = '0;
        if (!reset) begin
            unique case (state_q)
                StOwn0: begin
                    mem_read  = rd0 & req0;
                    mem_write = wr0 & req0;
                    mem_index = idx0;
                    mem_i     = i0;
                    mem_j     = j0;
                    mem_wdata = wdata0;
                end
                StOwn1: begin
                    mem_read  = rd1 & req1;
                    mem_write = wr1 & req1;
                    mem_index = idx1;
                    mem_i     = i1;
                    mem_j     = j1;
                    mem_wdata = wdata1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_port_arbiter.sv
// Bench for mm_port_arbiter: fixed vector table, hand-written corner sequences and a random
// run against a behavioural owner/last/held model. Honours MM_ARB_BURST_CAP_EN.
module tb_mm_port_arbiter;

    localparam int unsigned N         = 20;
    localparam int unsigned MAX_BURST = 4;
`ifdef MM_ARB_BURST_CAP_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           req0, req1, rd0, rd1, wr0, wr1, idx0, idx1;
    logic [N-1:0]   i0, i1, j0, j1;
    logic [2*N-1:0] wdata0, wdata1;
    logic           gnt0, gnt1, mem_read, mem_write, mem_index;
    logic [N-1:0]   mem_i, mem_j, mem_rdata, rdata;
    logic [2*N-1:0] mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: current owner (-1 = none), last served, cycles held by current owner.
    int m_owner, m_last, m_held;

    mm_port_arbiter #(.N(N), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .rd0(rd0), .rd1(rd1), .wr0(wr0), .wr1(wr1),
        .idx0(idx0), .idx1(idx1), .i0(i0), .i1(i1), .j0(j0), .j1(j1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .mem_read(mem_read), .mem_write(mem_write),
        .mem_index(mem_index), .mem_i(mem_i), .mem_j(mem_j), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rst, r0, r1, rd0, wr0, rd1, wr1;
        logic g0, g1, mr, mw;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
        wr0 = 1'b0; wr1 = 1'b0;
    endtask

    // Advance the model across one clock edge using the inputs of the current cycle.
    task automatic model_step();
        int o, p;
        logic [1:0] rq;
        rq = {req1, req0};
        if (reset) begin
            m_owner = -1; m_last = 1; m_held = 0;
        end else if (m_owner < 0) begin
            if (rq != 2'b00) begin
                m_owner = (rq == 2'b11) ? 1 - m_last : (rq[0] ? 0 : 1);
                m_held  = 1;
            end
        end else begin
            o = m_owner;
            p = 1 - o;
            if (!rq[o] || (CAP && m_held >= int'(MAX_BURST) && rq[p])) begin
                m_last = o;
                if (rq[p]) begin
                    m_owner = p; m_held = 1;
                end else begin
                    m_owner = -1; m_held = 0;
                end
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_model();
        logic          e_rd, e_wr, e_idx;
        logic [N-1:0]  e_i, e_j;
        logic [2*N-1:0] e_wd;
        e_rd = 1'b0; e_wr = 1'b0; e_idx = 1'b0; e_i = '0; e_j = '0; e_wd = '0;
        if (!reset && m_owner == 0) begin
            e_rd = rd0 & req0; e_wr = wr0 & req0; e_idx = idx0; e_i = i0; e_j = j0; e_wd = wdata0;
        end else if (!reset && m_owner == 1) begin
            e_rd = rd1 & req1; e_wr = wr1 & req1; e_idx = idx1; e_i = i1; e_j = j1; e_wd = wdata1;
        end
        if (!reset) begin
            check("rnd_gnt0", 64'(gnt0), 64'(m_owner == 0));
            check("rnd_gnt1", 64'(gnt1), 64'(m_owner == 1));
        end
        check("rnd_onehot", 64'(gnt0 & gnt1), 64'd0);
        check("rnd_read", 64'(mem_read), 64'(e_rd));
        check("rnd_write", 64'(mem_write), 64'(e_wr));
        check("rnd_index", 64'(mem_index), 64'(e_idx));
        check("rnd_i", 64'(mem_i), 64'(e_i));
        check("rnd_j", 64'(mem_j), 64'(e_j));
        check("rnd_wdata", 64'(mem_wdata), 64'(e_wd));
        check("rnd_rdata", 64'(rdata), 64'(mem_rdata));
    endtask

    vec_t vecs[17];

    initial begin
        int cnt1;
        bit seen0;

        vecs[0]  = 11'b1_00_0000_0000;
        vecs[1]  = 11'b0_10_1000_0000;
        vecs[2]  = 11'b0_10_1000_1010;
        vecs[3]  = 11'b0_11_0101_1001;
        vecs[4]  = 11'b0_01_0001_1000;
        vecs[5]  = 11'b0_01_0001_0101;
        vecs[6]  = 11'b0_00_0001_0100;
        vecs[7]  = 11'b0_00_0000_0000;
        vecs[8]  = 11'b0_11_0010_0000;
        vecs[9]  = 11'b0_11_0010_1000;
        vecs[10] = 11'b0_01_0010_1000;
        vecs[11] = 11'b0_11_0010_0110;
        vecs[12] = 11'b0_10_0010_0100;
        vecs[13] = 11'b0_10_1000_1010;
        vecs[14] = 11'b0_00_1000_1000;
        vecs[15] = 11'b0_11_0000_0000;
        vecs[16] = 11'b0_11_0000_0100;

        idle_inputs();
        reset = 1'b1;
        idx0 = 1'b0; idx1 = 1'b1;
        i0 = 20'd3; j0 = 20'd5; i1 = 20'd7; j1 = 20'd9;
        wdata0 = 40'h0abcd; wdata1 = 40'h12345;
        mem_rdata = 20'h5a5a5;
        next_cycle();

        // Table-driven sequence.
        for (int k = 0; k < 17; k++) begin
            reset = vecs[k].rst; req0 = vecs[k].r0; req1 = vecs[k].r1;
            rd0 = vecs[k].rd0; wr0 = vecs[k].wr0; rd1 = vecs[k].rd1; wr1 = vecs[k].wr1;
            @(negedge clk);
            check($sformatf("vec%0d_gnt0", k), 64'(gnt0), 64'(vecs[k].g0));
            check($sformatf("vec%0d_gnt1", k), 64'(gnt1), 64'(vecs[k].g1));
            check($sformatf("vec%0d_read", k), 64'(mem_read), 64'(vecs[k].mr));
            check($sformatf("vec%0d_write", k), 64'(mem_write), 64'(vecs[k].mw));
            next_cycle();
        end

        // Single read by requester 0 right after reset.
        idle_inputs(); reset = 1'b1; next_cycle();
        reset = 1'b0; req0 = 1'b1; rd0 = 1'b1;
        @(negedge clk);
        check("rd_gnt0_latency", 64'(gnt0), 64'd0);
        next_cycle();
        mem_rdata = 20'h0beef;
        @(negedge clk);
        check("rd_gnt0", 64'(gnt0), 64'd1);
        check("rd_mem_read", 64'(mem_read), 64'd1);
        check("rd_mem_i", 64'(mem_i), 64'd3);
        check("rd_mem_j", 64'(mem_j), 64'd5);
        check("rd_rdata", 64'(rdata), 64'h0beef);
        next_cycle();

        // Owner 1 write, then idle outputs all zero.
        idle_inputs(); next_cycle();
        req1 = 1'b1; wr1 = 1'b1; next_cycle();
        @(negedge clk);
        check("wr_gnt1", 64'(gnt1), 64'd1);
        check("wr_mem_write", 64'(mem_write), 64'd1);
        check("wr_mem_wdata", 64'(mem_wdata), 64'h12345);
        check("wr_mem_index", 64'(mem_index), 64'd1);
        check("wr_mem_i", 64'(mem_i), 64'd7);
        next_cycle();
        idle_inputs(); next_cycle();
        @(negedge clk);
        check("idle_gnt", 64'({gnt0, gnt1}), 64'd0);
        check("idle_mem", 64'({mem_read, mem_write, mem_index}), 64'd0);
        check("idle_addr", 64'({mem_i, mem_j}), 64'd0);
        check("idle_wdata", 64'(mem_wdata), 64'd0);
        next_cycle();

        // Burst: requester 1 holds req, requester 0 waits.
        req1 = 1'b1; wr1 = 1'b1; next_cycle();
        req0 = 1'b1; rd0 = 1'b1;
        cnt1 = 0; seen0 = 1'b0;
        for (int c = 0; c < 20 && !seen0; c++) begin
            @(negedge clk);
            if (gnt0) seen0 = 1'b1;
            else if (gnt1) cnt1++;
            if (!seen0) next_cycle();
        end
        check("burst_gnt1_cycles", 64'(cnt1), CAP ? 64'd4 : 64'd20);
        check("burst_handover", 64'(seen0), 64'(CAP));
        next_cycle();
        req1 = 1'b0; wr1 = 1'b0; next_cycle();
        @(negedge clk);
        check("burst_release_gnt0", 64'({gnt0, gnt1}), 64'b10);
        next_cycle();

        // Reset in the middle of an OWN1 write burst.
        idle_inputs(); next_cycle(); next_cycle();
        req1 = 1'b1; wr1 = 1'b1; next_cycle(); next_cycle();
        @(negedge clk);
        check("mid_pre_gnt1", 64'(gnt1), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_write", 64'(mem_write), 64'd0);
        next_cycle();
        @(negedge clk);
        check("mid_post_gnt1", 64'(gnt1), 64'd0);
        check("mid_post_write", 64'(mem_write), 64'd0);
        next_cycle();
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        check("mid_after_gnt", 64'({gnt0, gnt1}), 64'b00);
        next_cycle();
        @(negedge clk);
        check("mid_tie_gnt0", 64'({gnt0, gnt1}), 64'b10);
        next_cycle();

        // Random run against the model; first cycle is a reset to sync the model.
        for (int c = 0; c < 10000; c++) begin
            reset = (c == 0) || ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) req0 = ~req0;
            if ($urandom_range(0, 3) == 0) req1 = ~req1;
            rd0 = 1'($urandom); wr0 = 1'($urandom); rd1 = 1'($urandom); wr1 = 1'($urandom);
            idx0 = 1'($urandom); idx1 = 1'($urandom);
            i0 = N'($urandom); j0 = N'($urandom); i1 = N'($urandom); j1 = N'($urandom);
            wdata0 = {8'($urandom), 32'($urandom)};
            wdata1 = {8'($urandom), 32'($urandom)};
            mem_rdata = N'($urandom);
            @(negedge clk);
            check_model();
            model_step();
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
